// File: rtl/recon_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : recon_sample_scheduler
// Purpose  : Sequences reconstruction-filter flush/settle/run and decimates
//            filter output into a small output FIFO with overflow tracking.
// Revision : 1.0 - initial release
// ============================================================================
module recon_sample_scheduler #(
  parameter int IN_BW      = 24,
  parameter int CNT_BW     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic [CNT_BW-1:0]       i_cfg_div,
  input  logic [CNT_BW-1:0]       i_cfg_settle,
  input  logic signed [IN_BW-1:0] i_filt_out,
  output logic                    o_filt_reset,
  output logic signed [IN_BW-1:0] o_out_data,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic                    o_running,
  output logic                    o_overflow,
  output logic [7:0]              o_drop_count
);

  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_OCC_W = c_PTR_W + 1;
  localparam logic [CNT_BW-1:0]  c_CNT_ONE = CNT_BW'(1);
  localparam logic [CNT_BW:0]    c_INC_ONE = (CNT_BW+1)'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [c_OCC_W-1:0] c_OCC_ONE = c_OCC_W'(1);
  localparam logic [c_OCC_W-1:0] c_FULL    = c_OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_BW-1:0]   r_cnt;
  logic [CNT_BW-1:0]   r_div_m1;
  logic [CNT_BW-1:0]   r_settle;
  logic                r_filt_reset;
  logic                r_running;

  logic signed [IN_BW-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]      r_rd_ptr;
  logic [c_PTR_W-1:0]      r_wr_ptr;
  logic [c_OCC_W-1:0]      r_count;
  logic signed [IN_BW-1:0] r_out_data;
  logic                    r_out_valid;
  logic                    r_overflow;
  logic [7:0]              r_drop_count;

  logic                    w_capture;
  logic                    w_flush_entry;
  logic [CNT_BW:0]         w_cnt_inc;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_drop;
  logic [c_PTR_W-1:0]      w_rd_next;
  logic [c_OCC_W-1:0]      w_count_next;
  logic signed [IN_BW-1:0] w_head_next;

  assign w_capture     = (r_state == ST_RUN) && (r_cnt == r_div_m1);
  assign w_flush_entry = (r_state == ST_IDLE) && i_enable;
  assign w_cnt_inc     = {1'b0, r_cnt} + c_INC_ONE;

  // Filt_reset and running are computed from the next state so they line up
  // with the state register rather than lagging it by a cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_div_m1     <= '0;
      r_settle     <= '0;
      r_filt_reset <= 1'b1;
      r_running    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_enable) begin
            r_state  <= ST_FLUSH;
            r_cnt    <= '0;
            r_div_m1 <= (i_cfg_div == '0) ? '0 : (i_cfg_div - c_CNT_ONE);
            r_settle <= i_cfg_settle;
          end
        end
        ST_FLUSH: begin
          if (!i_enable) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == c_CNT_ONE) begin
            r_state      <= ST_SETTLE;
            r_cnt        <= '0;
            r_filt_reset <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        ST_SETTLE: begin
          if (!i_enable) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_filt_reset <= 1'b1;
          end else if (w_cnt_inc >= {1'b0, r_settle}) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_running <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!i_enable) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_filt_reset <= 1'b1;
            r_running    <= 1'b0;
          end else if (r_cnt == r_div_m1) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_cnt        <= '0;
          r_filt_reset <= 1'b1;
          r_running    <= 1'b0;
        end
      endcase
    end
  end

  assign w_full    = (r_count == c_FULL);
  assign w_pop     = r_out_valid & i_out_ready;
  assign w_push    = w_capture & (~w_full | w_pop);
  assign w_drop    = w_capture & w_full & ~w_pop;
  assign w_rd_next = w_pop ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;

  // When the new head slot is the one being written this cycle, bypass memory.
  assign w_head_next = (w_push && (w_rd_next == r_wr_ptr)) ? i_filt_out : r_mem[w_rd_next];

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + c_OCC_ONE;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - c_OCC_ONE;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_filt_out;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_flush_entry) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_out_valid  <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      r_rd_ptr    <= w_rd_next;
      r_count     <= w_count_next;
      r_out_valid <= (w_count_next != '0);
      if (w_count_next != '0) begin
        r_out_data <= w_head_next;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'd1;
        end
      end
    end
  end

  assign o_filt_reset = r_filt_reset;
  assign o_running    = r_running;
  assign o_out_data   = r_out_data;
  assign o_out_valid  = r_out_valid;
  assign o_overflow   = r_overflow;
  assign o_drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_recon_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_recon_sample_scheduler
// Purpose  : Directed self-checking bench for recon_sample_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_recon_sample_scheduler;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] div;
  logic [15:0] settle;
  logic [23:0] filt;
  logic        fr;
  logic [23:0] odata;
  logic        ovalid;
  logic        rdy;
  logic        run;
  logic        ovf;
  logic [7:0]  drops;

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;
  int tf = 0;

  recon_sample_scheduler dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_enable     (en),
    .i_cfg_div    (div),
    .i_cfg_settle (settle),
    .i_filt_out   (filt),
    .o_filt_reset (fr),
    .o_out_data   (odata),
    .o_out_valid  (ovalid),
    .i_out_ready  (rdy),
    .o_running    (run),
    .o_overflow   (ovf),
    .o_drop_count (drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Filter output in the cycle ending at edge n.
  function automatic logic [23:0] val(input int n);
    return 24'h100000 + 24'(n);
  endfunction

  task automatic tick();
    t++;
    filt = val(t);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_filt_reset"}, 32'(fr), 32'd1);
    chk({tag, "_running"},    32'(run), 32'd0);
    chk({tag, "_valid"},      32'(ovalid), 32'd0);
    chk({tag, "_data"},       32'(odata), 32'd0);
    chk({tag, "_overflow"},   32'(ovf), 32'd0);
    chk({tag, "_drops"},      32'(drops), 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rdy = 1'b0; div = 16'd0; settle = 16'd0; filt = '0;
    tick(); tick(); tick();
    chk_reset_state("rst");

    // Start sequence, div=4 settle=3, consumer always ready
    rst = 1'b0; en = 1'b1; div = 16'd4; settle = 16'd3; rdy = 1'b1;
    tick(); chk("b_flush1_fr", 32'(fr), 32'd1); chk("b_flush1_run", 32'(run), 32'd0);
    div = 16'd7; settle = 16'd9;
    tick(); chk("b_flush2_fr", 32'(fr), 32'd1);
    tick(); chk("b_settle_fr", 32'(fr), 32'd0); chk("b_settle_run", 32'(run), 32'd0);
    tick(); tick(); chk("b_settle3_run", 32'(run), 32'd0);
    tick(); chk("b_run_entry", 32'(run), 32'd1);
    tick(); tick(); tick(); chk("b_nocap_valid", 32'(ovalid), 32'd0);
    tick(); chk("b_cap1_valid", 32'(ovalid), 32'd1); chk("b_cap1_data", 32'(odata), 32'(val(t)));
    tick(); chk("b_pop_valid", 32'(ovalid), 32'd0);
    tick(); tick(); chk("b_gap_valid", 32'(ovalid), 32'd0);
    tick(); chk("b_cap2_valid", 32'(ovalid), 32'd1); chk("b_cap2_data", 32'(odata), 32'(val(t)));

    // Zero config with backpressure; abort on the sixth RUN cycle
    en = 1'b0; rdy = 1'b0;
    tick(); chk("c_idle_fr", 32'(fr), 32'd1); chk("c_idle_run", 32'(run), 32'd0);
    en = 1'b1; div = 16'd0; settle = 16'd0;
    tick(); chk("c_flush_valid", 32'(ovalid), 32'd0);
    tick(); tick(); chk("c_settle_fr", 32'(fr), 32'd0);
    tick(); chk("c_run", 32'(run), 32'd1); chk("c_run_valid", 32'(ovalid), 32'd0);
    tick(); tf = t; chk("c_cap1_valid", 32'(ovalid), 32'd1); chk("c_cap1_data", 32'(odata), 32'(val(tf)));
    tick(); tick(); tick(); chk("c_full_ovf", 32'(ovf), 32'd0); chk("c_full_data", 32'(odata), 32'(val(tf)));
    tick(); chk("c_drop1_ovf", 32'(ovf), 32'd1); chk("c_drop1_cnt", 32'(drops), 32'd1);
    en = 1'b0;
    tick(); chk("c_abort_run", 32'(run), 32'd0); chk("c_abort_fr", 32'(fr), 32'd1);
    chk("c_drop2_cnt", 32'(drops), 32'd2); chk("c_hold_data", 32'(odata), 32'(val(tf)));
    rdy = 1'b1;
    tick(); chk("c_drain1", 32'(odata), 32'(val(tf + 1)));
    tick(); chk("c_drain2", 32'(odata), 32'(val(tf + 2)));
    tick(); chk("c_drain3", 32'(odata), 32'(val(tf + 3)));
    tick(); chk("c_drain_empty", 32'(ovalid), 32'd0); chk("c_idle_ovf", 32'(ovf), 32'd1);

    // Full FIFO with a pop in the capture cycle
    rdy = 1'b0; en = 1'b1; div = 16'd1; settle = 16'd0;
    tick(); chk("d_clr_ovf", 32'(ovf), 32'd0); chk("d_clr_drops", 32'(drops), 32'd0);
    chk("d_clr_valid", 32'(ovalid), 32'd0);
    tick(); tick(); tick(); chk("d_run", 32'(run), 32'd1);
    tick(); tf = t;
    tick(); tick(); tick();
    rdy = 1'b1;
    tick(); chk("d_popcap_drops", 32'(drops), 32'd0); chk("d_popcap_ovf", 32'(ovf), 32'd0);
    chk("d_popcap_data", 32'(odata), 32'(val(tf + 1)));
    en = 1'b0;
    tick(); chk("d_abort_data", 32'(odata), 32'(val(tf + 2))); chk("d_abort_run", 32'(run), 32'd0);
    tick(); chk("d_drain1", 32'(odata), 32'(val(tf + 3)));
    tick(); chk("d_drain2", 32'(odata), 32'(val(tf + 4)));
    tick(); chk("d_drain3", 32'(odata), 32'(val(tf + 5)));
    tick(); chk("d_empty", 32'(ovalid), 32'd0); chk("d_drops_end", 32'(drops), 32'd0);

    // Abort with three samples queued, then drain in IDLE
    rdy = 1'b0; en = 1'b1; div = 16'd2; settle = 16'd1;
    tick(); tick(); tick(); tick(); chk("e_run", 32'(run), 32'd1);
    tick(); chk("e_nocap", 32'(ovalid), 32'd0);
    tick(); tf = t; chk("e_cap1", 32'(odata), 32'(val(tf)));
    tick(); tick(); tick(); tick();
    en = 1'b0;
    tick(); chk("e_idle_fr", 32'(fr), 32'd1); chk("e_idle_run", 32'(run), 32'd0);
    chk("e_idle_valid", 32'(ovalid), 32'd1); chk("e_idle_data", 32'(odata), 32'(val(tf)));
    rdy = 1'b1;
    tick(); chk("e_drain1", 32'(odata), 32'(val(tf + 2)));
    tick(); chk("e_drain2", 32'(odata), 32'(val(tf + 4)));
    tick(); chk("e_empty", 32'(ovalid), 32'd0);

    // Reset mid-RUN, reset priority, restart, drop counter saturation
    rdy = 1'b0; en = 1'b1; div = 16'd1; settle = 16'd0;
    tick(); tick(); tick(); tick(); tick(); tick();
    chk("f_pre_valid", 32'(ovalid), 32'd1); chk("f_pre_run", 32'(run), 32'd1);
    rst = 1'b1;
    tick(); chk_reset_state("f_rst");
    tick(); chk("f_rst_hold_fr", 32'(fr), 32'd1); chk("f_rst_hold_run", 32'(run), 32'd0);
    rst = 1'b0;
    tick(); chk("f_flush_fr", 32'(fr), 32'd1); chk("f_flush_valid", 32'(ovalid), 32'd0);
    tick(); tick(); chk("f_settle_fr", 32'(fr), 32'd0);
    tick(); chk("f_run", 32'(run), 32'd1);
    repeat (300) tick();
    chk("f_sat_drops", 32'(drops), 32'd255); chk("f_sat_ovf", 32'(ovf), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
